// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue between multi-cycle producers and the register file's single write port.
// Define WBQ_FORWARD_EN to build the read-side forwarding of pending write data.
module regfile_writeback_queue #(
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_rd,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [AW-1:0]            rs1,
    input  logic [AW-1:0]            rs2,
    output logic                     fwd1_hit,
    output logic [XLEN-1:0]          fwd1_data,
    output logic                     fwd2_hit,
    output logic [XLEN-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            enq;
    logic            deq;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    // Writes to x0 finish the handshake but never occupy a slot.
    assign push = in_valid && in_ready;
    assign enq  = push && (in_rd != '0);

    assign rf_we    = !empty && drain_en && !reset;
    assign deq      = rf_we;
    assign rf_rd    = rd_mem[rd_ptr];
    assign rf_wdata = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Walk from head to tail so a later (younger) match overrides an older one.
    function automatic logic [XLEN:0] fwd_lookup(input logic [AW-1:0] rs);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (rs != '0) && (rd_mem[idx] == rs))
                res = {1'b1, data_mem[idx]};
        end
        return res;
    endfunction

    logic [XLEN:0] fwd1_res;
    logic [XLEN:0] fwd2_res;

    always_comb begin
        fwd1_res = fwd_lookup(rs1);
        fwd2_res = fwd_lookup(rs2);
    end

    assign fwd1_hit  = fwd1_res[XLEN];
    assign fwd1_data = fwd1_res[XLEN-1:0];
    assign fwd2_hit  = fwd2_res[XLEN];
    assign fwd2_data = fwd2_res[XLEN-1:0];
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};

    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule
